// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing package.
// Provides the default hypervector width, the hypervector type and the
// bundle-window sequencer state encoding.
// No ports (package).
package hdc_pkg;

  localparam int DIMENSIONS = 5;

  typedef logic [DIMENSIONS-1:0] hv_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    BUNDLE = 2'd1,
    OUT    = 2'd2
  } bundle_state_t;

endpackage : hdc_pkg

// File: rtl/bundler_ch_v2.sv
// Per-channel majority bundler (purely combinational).
// Each output bit is the majority of the corresponding bits of the NUM_HVS
// input hypervectors. An even split resolves to 1, so with even NUM_HVS a bit
// is set when at least half of the inputs have it set.
// Ports:
//   hv_array  input  NUM_HVS x DIMENSIONS  hypervectors to bundle
//   hvout     output DIMENSIONS            bundled hypervector
module bundler_ch_v2 #(
  parameter int DIMENSIONS = 5,
  parameter int NUM_HVS    = 4
) (
  input  logic [DIMENSIONS-1:0] hv_array [NUM_HVS],
  output logic [DIMENSIONS-1:0] hvout
);

  localparam int CW = $clog2(NUM_HVS + 1);

  logic [CW-1:0] ones_s;

  // Per-bit population count followed by a "at least half" threshold.
  always_comb begin
    hvout  = '0;
    ones_s = '0;
    for (int d = 0; d < DIMENSIONS; d++) begin
      ones_s = '0;
      for (int i = 0; i < NUM_HVS; i++) begin
        ones_s = ones_s + {{(CW-1){1'b0}}, hv_array[i][d]};
      end
      // 2*ones >= NUM_HVS: strict majority for odd windows, tie -> 1 for even.
      hvout[d] = ({ones_s, 1'b0} >= (CW+1)'(NUM_HVS));
    end
  end

endmodule : bundler_ch_v2

// File: rtl/bundle_window_ctrl.sv
// Window sequencer for the per-channel majority bundler.
// Collects NUM_HVS hypervectors (slot[0] = oldest) over a valid/ready
// handshake, bundles them in one cycle and holds the registered result for
// the downstream stage until it is accepted.
// Ports:
//   clk        input   system clock, rising edge
//   rst_n      input   asynchronous active-low reset
//   in_hv      input   incoming hypervector
//   in_valid   input   in_hv valid
//   in_ready   output  controller can accept in_hv this cycle
//   flush      input   discard a partially filled window (FILL only)
//   out_hv     output  registered bundled hypervector
//   out_valid  output  out_hv valid
//   out_ready  input   downstream accepts out_hv
//   fill_cnt   output  slots currently filled (0..NUM_HVS)
// Optional macro BUNDLE_WINDOW_CNT_EN adds:
//   win_cnt    output  completed output handshakes, 16-bit wrapping
//   flush_drop output  one-cycle pulse after a flush that discarded data
module bundle_window_ctrl
  import hdc_pkg::*;
#(
  parameter  int DIMENSIONS = hdc_pkg::DIMENSIONS,
  parameter  int NUM_HVS    = 4,
  localparam int CNT_W      = $clog2(NUM_HVS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DIMENSIONS-1:0] out_hv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      fill_cnt
`ifdef BUNDLE_WINDOW_CNT_EN
  ,
  output logic [15:0]           win_cnt,
  output logic                  flush_drop
`endif
);

  bundle_state_t         state_r;
  bundle_state_t         state_s;
  logic [CNT_W-1:0]      fill_cnt_r;
  logic [DIMENSIONS-1:0] slot_r [NUM_HVS];
  logic [DIMENSIONS-1:0] out_hv_r;
  logic                  out_valid_r;
  logic [DIMENSIONS-1:0] bundle_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  handshake_s;
  logic                  flush_s;

  bundler_ch_v2 #(
    .DIMENSIONS (DIMENSIONS),
    .NUM_HVS    (NUM_HVS)
  ) u_bundler (
    .hv_array (slot_r),
    .hvout    (bundle_s)
  );

  // Next-state and handshake decode.
  always_comb begin
    state_s     = state_r;
    in_ready_s  = 1'b0;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      FILL: begin
        // Held low while in reset so nothing upstream believes it was taken.
        in_ready_s = rst_n & ~flush;
        accept_s   = in_valid & in_ready_s;
        flush_s    = flush;
        if (accept_s && (fill_cnt_r == CNT_W'(NUM_HVS - 1))) begin
          state_s = BUNDLE;
        end else begin
          state_s = FILL;
        end
      end
      BUNDLE: begin
        state_s = OUT;
      end
      OUT: begin
        handshake_s = out_valid_r & out_ready;
        if (handshake_s) begin
          state_s = FILL;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FILL;
    end else begin
      state_r <= state_s;
    end
  end

  // Fill counter: cleared by flush or output handshake, bumped on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= '0;
    end else if (flush_s || handshake_s) begin
      fill_cnt_r <= '0;
    end else if (accept_s) begin
      fill_cnt_r <= fill_cnt_r + CNT_W'(1);
    end
  end

  // Slot buffer written in arrival order; stale contents are never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_HVS; i++) begin
        slot_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_HVS; i++) begin
        if (accept_s && (fill_cnt_r == CNT_W'(i))) begin
          slot_r[i] <= in_hv;
        end
      end
    end
  end

  // Output register: captured in BUNDLE, held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hv_r    <= '0;
      out_valid_r <= 1'b0;
    end else if (state_r == BUNDLE) begin
      out_hv_r    <= bundle_s;
      out_valid_r <= 1'b1;
    end else if (handshake_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_hv    = out_hv_r;
  assign out_valid = out_valid_r;
  assign fill_cnt  = fill_cnt_r;

`ifdef BUNDLE_WINDOW_CNT_EN
  logic [15:0] win_cnt_r;
  logic        flush_drop_r;

  // Window counter and discarded-flush pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r    <= 16'd0;
      flush_drop_r <= 1'b0;
    end else begin
      if (handshake_s) begin
        win_cnt_r <= win_cnt_r + 16'd1;
      end
      flush_drop_r <= flush_s & (fill_cnt_r != '0);
    end
  end

  assign win_cnt    = win_cnt_r;
  assign flush_drop = flush_drop_r;
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule : bundle_window_ctrl

// File: tb/tb_bundle_window_ctrl.sv
module tb_bundle_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] in_hv = 5'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic [4:0] out_hv;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [2:0] fill_cnt;

  logic [4:0] in_hv3 = 5'd0;
  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic       flush3 = 1'b0;
  logic [4:0] out_hv3;
  logic       out_valid3;
  logic       out_ready3 = 1'b1;
  logic [1:0] fill_cnt3;

`ifdef BUNDLE_WINDOW_CNT_EN
  logic [15:0] win_cnt;
  logic        flush_drop;
  logic [15:0] win_cnt3;
  logic        flush_drop3;
`endif

  int n_chk = 0;
  int n_bad = 0;
  logic [4:0] exp_q [$];
  logic [4:0] exp_v;

  always #5 clk = ~clk;

  bundle_window_ctrl #(.DIMENSIONS(5), .NUM_HVS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_hv(in_hv), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_hv(out_hv),
    .out_valid(out_valid), .out_ready(out_ready), .fill_cnt(fill_cnt)
`ifdef BUNDLE_WINDOW_CNT_EN
    , .win_cnt(win_cnt), .flush_drop(flush_drop)
`endif
  );

  bundle_window_ctrl #(.DIMENSIONS(5), .NUM_HVS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_hv(in_hv3), .in_valid(in_valid3),
    .in_ready(in_ready3), .flush(flush3), .out_hv(out_hv3),
    .out_valid(out_valid3), .out_ready(out_ready3), .fill_cnt(fill_cnt3)
`ifdef BUNDLE_WINDOW_CNT_EN
    , .win_cnt(win_cnt3), .flush_drop(flush_drop3)
`endif
  );

  // Present one vector at a negedge; report whether it is taken at the next posedge.
  task automatic send(input logic [4:0] hv, output bit acc);
    in_hv    = hv;
    in_valid = 1'b1;
    #1;
    acc = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_hv     = 5'b10101;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_hv !== 5'b00000) begin n_bad++; $display("FAIL reset_out_hv: got %b want 00000", out_hv); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    n_chk++; if (fill_cnt !== 3'd0) begin n_bad++; $display("FAIL post_reset_fill_cnt: got %0d want 0", fill_cnt); end
    @(negedge clk);
  endtask

  task automatic test_window();
    logic [4:0] vecs [4] = '{5'b11100, 5'b11010, 5'b11001, 5'b00000};
    bit acc;
    out_ready = 1'b1;
    exp_q.push_back(5'b11000);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i], acc);
      n_chk++; if (acc !== 1'b1) begin n_bad++; $display("FAIL win_accept%0d: in_ready got %b want 1", i, acc); end
      if (i == 1) begin
        n_chk++; if (fill_cnt !== 3'd2) begin n_bad++; $display("FAIL win_fill2: got %0d want 2", fill_cnt); end
      end
    end
    // One edge after the last accept: BUNDLE.
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL win_bundle_valid: got %b want 0", out_valid); end
    n_chk++; if (fill_cnt !== 3'd4) begin n_bad++; $display("FAIL win_bundle_fill: got %0d want 4", fill_cnt); end
    n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL win_bundle_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    // Two edges after the last accept: OUT.
    n_chk++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL win_latency: out_valid got %b want 1", out_valid); end
    exp_v = exp_q.pop_front();
    n_chk++; if (out_hv !== exp_v) begin n_bad++; $display("FAIL win_out_hv: got %b want %b", out_hv, exp_v); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL win_post_valid: got %b want 0", out_valid); end
    n_chk++; if (fill_cnt !== 3'd0) begin n_bad++; $display("FAIL win_post_fill: got %0d want 0", fill_cnt); end
    n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL win_post_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [4:0] vecs [4] = '{5'b01110, 5'b01111, 5'b00001, 5'b11111};
    bit acc;
    int k;
    out_ready = 1'b0;
    exp_q.push_back(5'b01111);
    for (int i = 0; i < 4; i++) send(vecs[i], acc);
    k = 0;
    while (!out_valid && k < 8) begin @(negedge clk); k++; end
    n_chk++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: out_valid got %b want 1", out_valid); end
    exp_v = exp_q[0];
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_hv    = 5'($urandom_range(31, 0));
      #1;
      n_chk++; if (out_valid !== 1'b1 || out_hv !== exp_v) begin n_bad++; $display("FAIL bp_hold%0d: got %b/%b want 1/%b", c, out_valid, out_hv, exp_v); end
      n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); end
      n_chk++; if (fill_cnt !== 3'd4) begin n_bad++; $display("FAIL bp_fill%0d: got %0d want 4", c, fill_cnt); end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_v = exp_q.pop_front();
    #1;
    n_chk++; if (out_hv !== exp_v) begin n_bad++; $display("FAIL bp_out_hv: got %b want %b", out_hv, exp_v); end
    n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_bypass: in_ready got %b want 0", in_ready); end
    @(negedge clk);
    n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    n_chk++; if (fill_cnt !== 3'd0) begin n_bad++; $display("FAIL bp_release_fill: got %0d want 0", fill_cnt); end
  endtask

  task automatic test_flush();
    logic [4:0] vecs [4] = '{5'b10101, 5'b10110, 5'b00111, 5'b10100};
    bit acc;
    int k;
    out_ready = 1'b1;
    send(5'b11111, acc);
    send(5'b11111, acc);
    n_chk++; if (fill_cnt !== 3'd2) begin n_bad++; $display("FAIL flush_pre_fill: got %0d want 2", fill_cnt); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_hv    = 5'b11111;
    #1;
    n_chk++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    n_chk++; if (fill_cnt !== 3'd0) begin n_bad++; $display("FAIL flush_fill: got %0d want 0", fill_cnt); end
`ifdef BUNDLE_WINDOW_CNT_EN
    n_chk++; if (flush_drop !== 1'b1) begin n_bad++; $display("FAIL flush_drop_pulse: got %b want 1", flush_drop); end
    @(negedge clk);
    n_chk++; if (flush_drop !== 1'b0) begin n_bad++; $display("FAIL flush_drop_once: got %b want 0", flush_drop); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_chk++; if (flush_drop !== 1'b0) begin n_bad++; $display("FAIL flush_drop_empty: got %b want 0", flush_drop); end
`endif
    exp_q.push_back(5'b10111);
    for (int i = 0; i < 4; i++) begin
      send(vecs[i], acc);
      n_chk++; if (acc !== 1'b1) begin n_bad++; $display("FAIL flush_win_accept%0d: got %b want 1", i, acc); end
    end
    k = 0;
    while (!out_valid && k < 8) begin @(negedge clk); k++; end
    n_chk++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_win_timeout: got %b want 1", out_valid); end
    exp_v = exp_q.pop_front();
    n_chk++; if (out_hv !== exp_v) begin n_bad++; $display("FAIL flush_win_out_hv: got %b want %b", out_hv, exp_v); end
    @(negedge clk);
`ifdef BUNDLE_WINDOW_CNT_EN
    n_chk++; if (win_cnt !== 16'd3) begin n_bad++; $display("FAIL win_cnt: got %0d want 3", win_cnt); end
`endif
  endtask

  task automatic test_odd();
    logic [4:0] vecs [3] = '{5'b00011, 5'b00110, 5'b01100};
    int k;
    out_ready3 = 1'b0;
    exp_q.push_back(5'b00110);
    for (int i = 0; i < 3; i++) begin
      in_hv3    = vecs[i];
      in_valid3 = 1'b1;
      #1;
      n_chk++; if (in_ready3 !== 1'b1) begin n_bad++; $display("FAIL odd_accept%0d: got %b want 1", i, in_ready3); end
      @(negedge clk);
    end
    in_valid3 = 1'b0;
    k = 0;
    while (!out_valid3 && k < 8) begin @(negedge clk); k++; end
    n_chk++; if (out_valid3 !== 1'b1) begin n_bad++; $display("FAIL odd_timeout: got %b want 1", out_valid3); end
    flush3 = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (out_valid3 !== 1'b1) begin n_bad++; $display("FAIL odd_flush_valid: got %b want 1", out_valid3); end
    n_chk++; if (fill_cnt3 !== 2'd3) begin n_bad++; $display("FAIL odd_flush_fill: got %0d want 3", fill_cnt3); end
    exp_v = exp_q.pop_front();
    n_chk++; if (out_hv3 !== exp_v) begin n_bad++; $display("FAIL odd_out_hv: got %b want %b", out_hv3, exp_v); end
    out_ready3 = 1'b1;
    @(negedge clk);
    flush3 = 1'b0;
    n_chk++; if (out_valid3 !== 1'b0) begin n_bad++; $display("FAIL odd_delivered: got %b want 0", out_valid3); end
    n_chk++; if (fill_cnt3 !== 2'd0) begin n_bad++; $display("FAIL odd_post_fill: got %0d want 0", fill_cnt3); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_window();
    test_backpressure();
    test_flush();
    test_odd();
    n_chk++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_bundle_window_ctrl
